// File: rtl/key_event_queue_if.sv
// Key-event handshake between the keypad event queue and the calculator control FSM.
// The master drives the head-of-queue key code and valid; the slave returns ready.
interface key_event_queue_if #(
  parameter int CODE_W = 4
);
  logic [CODE_W-1:0] key_code;
  logic              key_valid;
  logic              key_ready;

  modport master (output key_code, output key_valid, input key_ready);
  modport slave  (input key_code, input key_valid, output key_ready);
endinterface

// File: rtl/key_event_queue.sv
// Keypad press detector and event FIFO feeding the calculator control FSM.
// Optional auto-repeat for a sole held key is enabled by KEY_EVENT_QUEUE_AUTO_REPEAT_EN.
module key_event_queue #(
  parameter int N_KEYS        = 16,
  parameter int CODE_W        = $clog2(N_KEYS),
  parameter int FIFO_DEPTH    = 4,
  parameter int REPEAT_DELAY  = 25_000_000,
  parameter int REPEAT_PERIOD = 5_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] keys_in,
  key_event_queue_if.master evt,
  output logic              any_key,
  output logic              overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  if (N_KEYS < 2 || N_KEYS > 32 || FIFO_DEPTH < 2 || FIFO_DEPTH > 16 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
    $error("key_event_queue: illegal parameter set");
  end

  function automatic logic [CODE_W-1:0] lowest_idx(input logic [N_KEYS-1:0] v);
    logic [CODE_W-1:0] idx;
    idx = '0;
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      if (v[i]) idx = CODE_W'(i);
    end
    return idx;
  endfunction

  logic [N_KEYS-1:0] keys_q;
  logic [N_KEYS-1:0] pending;
  logic [N_KEYS-1:0] edge_m;
  logic [N_KEYS-1:0] clr_m;
  logic [N_KEYS-1:0] rpt_set;
  logic [CODE_W-1:0] push_idx;
  logic [CODE_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic              push;
  logic              pop;
  logic              can_accept;
  logic              lost;

  assign edge_m     = keys_in & ~keys_q;
  assign pop        = evt.key_valid & evt.key_ready;
  assign can_accept = (count < CNT_W'(FIFO_DEPTH)) || pop;
  assign push       = (|pending) && can_accept;
  assign push_idx   = lowest_idx(pending);
  assign clr_m      = push ? (N_KEYS'(1) << push_idx) : '0;
  // A fresh press on a bit still waiting to be queued is merged and flagged.
  assign lost       = |(edge_m & pending & ~clr_m);

  assign evt.key_valid = (count != '0);
  assign evt.key_code  = evt.key_valid ? fifo_mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      keys_q   <= '1;
      any_key  <= 1'b0;
      pending  <= '0;
      overflow <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      keys_q  <= keys_in;
      any_key <= |keys_in;
      pending <= (pending & ~clr_m) | edge_m | rpt_set;
      if (lost) overflow <= 1'b1;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= push_idx;
  end

`ifdef KEY_EVENT_QUEUE_AUTO_REPEAT_EN
  typedef enum logic {PH_DELAY, PH_PERIOD} phase_t;

  phase_t            phase;
  phase_t            phase_nxt;
  logic [N_KEYS-1:0] keys_qq;
  logic [31:0]       rpt_cnt;
  logic              hold_ok;
  logic              delay_done;
  logic              period_done;
  logic              rpt_fire;

  // Counting only while exactly one key is down and the key set is steady.
  assign hold_ok     = $onehot(keys_q) && (keys_q == keys_qq);
  assign delay_done  = (rpt_cnt == 32'(REPEAT_DELAY - 1));
  assign period_done = (rpt_cnt == 32'(REPEAT_PERIOD - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) phase <= PH_DELAY;
    else        phase <= phase_nxt;
  end

  always_comb begin
    phase_nxt = phase;
    if (!hold_ok)                         phase_nxt = PH_DELAY;
    else if (phase == PH_DELAY && delay_done) phase_nxt = PH_PERIOD;
  end

  always_comb begin
    rpt_fire = 1'b0;
    if (hold_ok) begin
      rpt_fire = (phase == PH_DELAY) ? delay_done : period_done;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      keys_qq <= '1;
      rpt_cnt <= '0;
    end else begin
      keys_qq <= keys_q;
      if (!hold_ok || rpt_fire) rpt_cnt <= '0;
      else                      rpt_cnt <= rpt_cnt + 32'd1;
    end
  end

  assign rpt_set = rpt_fire ? keys_q : '0;
`else
  assign rpt_set = '0;
`endif

endmodule

// File: tb/tb_key_event_queue.sv
// Directed bench for key_event_queue: vector table plus hand-written multi-cycle sequences.
// Built with KEY_EVENT_QUEUE_AUTO_REPEAT_EN it also expects auto-repeat events.
module tb_key_event_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] keys_in;
  logic        any_key;
  logic        overflow;

  int n_cmp  = 0;
  int n_fail = 0;

  key_event_queue_if #(.CODE_W(4)) kif ();

  key_event_queue #(
    .N_KEYS(16), .CODE_W(4), .FIFO_DEPTH(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .keys_in(keys_in), .evt(kif.master),
    .any_key(any_key), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic [15:0] keys;
    logic        rdy;
    logic        exp_valid;
    logic [3:0]  exp_code;
    logic        exp_ovf;
    logic        exp_any;
  } vec_t;

  vec_t vt [11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    int ev;
    // press key 5, hold head with ready low, then pop
    vt[0]  = '{1'b1, 16'h0020, 1'b0, 1'b0, 4'd0,  1'b0, 1'b1};
    vt[1]  = '{1'b1, 16'h0020, 1'b0, 1'b1, 4'd5,  1'b0, 1'b1};
    vt[2]  = '{1'b1, 16'h0020, 1'b0, 1'b1, 4'd5,  1'b0, 1'b1};
    vt[3]  = '{1'b1, 16'h0020, 1'b1, 1'b0, 4'd0,  1'b0, 1'b1};
    vt[4]  = '{1'b1, 16'h0000, 1'b0, 1'b0, 4'd0,  1'b0, 1'b0};
    // keys 3, 9, 12 together, drained in index order
    vt[5]  = '{1'b1, 16'h1208, 1'b1, 1'b0, 4'd0,  1'b0, 1'b1};
    vt[6]  = '{1'b1, 16'h1208, 1'b1, 1'b1, 4'd3,  1'b0, 1'b1};
    vt[7]  = '{1'b1, 16'h1208, 1'b1, 1'b1, 4'd9,  1'b0, 1'b1};
    vt[8]  = '{1'b1, 16'h1208, 1'b1, 1'b1, 4'd12, 1'b0, 1'b1};
    vt[9]  = '{1'b1, 16'h1208, 1'b1, 1'b0, 4'd0,  1'b0, 1'b1};
    vt[10] = '{1'b1, 16'h0000, 1'b0, 1'b0, 4'd0,  1'b0, 1'b0};

    // reset with key 0 held: no event after release
    rst_n = 1'b0; keys_in = 16'h0001; kif.key_ready = 1'b0;
    tick(); tick();
    check("rst_valid", 32'(kif.key_valid), 32'd0);
    check("rst_code",  32'(kif.key_code),  32'd0);
    check("rst_ovf",   32'(overflow),      32'd0);
    check("rst_any",   32'(any_key),       32'd0);
    rst_n = 1'b1;
    ev = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (kif.key_valid) ev++;
    end
    check("held_through_rst_events", 32'(ev), 32'd0);
    check("held_any", 32'(any_key), 32'd1);
    keys_in = 16'h0000;
    tick(); tick(); tick();
    check("release_valid", 32'(kif.key_valid), 32'd0);

    for (int i = 0; i < 11; i++) begin
      rst_n = vt[i].rst_n; keys_in = vt[i].keys; kif.key_ready = vt[i].rdy;
      tick();
      check($sformatf("vec%0d_valid", i), 32'(kif.key_valid), 32'(vt[i].exp_valid));
      check($sformatf("vec%0d_code", i),  32'(kif.key_code),  32'(vt[i].exp_code));
      check($sformatf("vec%0d_ovf", i),   32'(overflow),      32'(vt[i].exp_ovf));
      check($sformatf("vec%0d_any", i),   32'(any_key),       32'(vt[i].exp_any));
    end

    // fill FIFO with 0..3, leave 4 and 5 pending, then re-press 4
    kif.key_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      keys_in = 16'(1) << k; tick(); tick();
      keys_in = 16'h0000;    tick(); tick();
    end
    check("full_valid", 32'(kif.key_valid), 32'd1);
    check("full_head",  32'(kif.key_code),  32'd0);
    check("full_ovf",   32'(overflow),      32'd0);
    keys_in = 16'h0010; tick();
    check("repress_ovf", 32'(overflow), 32'd1);
    keys_in = 16'h0000; tick();
    kif.key_ready = 1'b1;
    for (int j = 0; j < 6; j++) begin
      check($sformatf("drain%0d_valid", j), 32'(kif.key_valid), 32'd1);
      check($sformatf("drain%0d_code", j),  32'(kif.key_code),  32'(j));
      tick();
    end
    check("drain_empty", 32'(kif.key_valid), 32'd0);
    tick(); tick(); tick();
    check("drain_no_dup", 32'(kif.key_valid), 32'd0);
    check("ovf_sticky",   32'(overflow),      32'd1);

    // reset while three events are queued
    kif.key_ready = 1'b0;
    keys_in = 16'h000E; tick();
    keys_in = 16'h0000; tick(); tick(); tick(); tick();
    check("q3_valid", 32'(kif.key_valid), 32'd1);
    check("q3_head",  32'(kif.key_code),  32'd1);
    rst_n = 1'b0; tick();
    check("midrst_valid", 32'(kif.key_valid), 32'd0);
    check("midrst_code",  32'(kif.key_code),  32'd0);
    check("midrst_ovf",   32'(overflow),      32'd0);
    rst_n = 1'b1; tick();
    keys_in = 16'h0080; tick();
    check("k7_not_yet", 32'(kif.key_valid), 32'd0);
    tick();
    check("k7_valid", 32'(kif.key_valid), 32'd1);
    check("k7_code",  32'(kif.key_code),  32'd7);
    kif.key_ready = 1'b1; tick();
    check("k7_popped", 32'(kif.key_valid), 32'd0);
    keys_in = 16'h0000; tick(); tick();

    // hold key 2 for 40 cycles with ready high and count delivered events
    ev = 0;
    keys_in = 16'h0004;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (kif.key_valid) ev++;
    end
    keys_in = 16'h0000;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (kif.key_valid) ev++;
    end
`ifdef KEY_EVENT_QUEUE_AUTO_REPEAT_EN
    check("hold_events", 32'(ev), 32'd5);
`else
    check("hold_events", 32'(ev), 32'd1);
`endif
    check("hold_ovf", 32'(overflow), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
